tx_serializer: RTL and testbench

- Transmit-side counterpart of the PHY Wi-Fi RX deserializer. Accepts parallel words from the AHB peripheral side over a valid/ready handshake and shifts them out LSB first as a serial bit stream with a per-bit write-enable. A frame ends on a word marked last, which may be shorter than DATA_WIDTH.
- Raises a maskable, sticky completion interrupt at end of frame.
- Double-buffered (holding register plus shift register), so back-to-back words stream with no gap in bit_valid.

---
 rtl/phy_wifi_pkg.sv | 13 +
 rtl/tx_hold_buf.sv | 59 +++++
 rtl/tx_serializer.sv | 150 +++++++++++++++
 tb/tb_tx_serializer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_wifi_pkg.sv
// Shared definitions for the PHY Wi-Fi transmit path: FSM encoding and width defaults.
package phy_wifi_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W_DEF      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tx_hold_buf.sv
// Holding register in front of the shifter: accepts one word over valid/ready
// and hands it to the shifter on pop. A load and a pop on the same edge keep it full.
module tx_hold_buf
  import phy_wifi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic [CNT_W-1:0]      i_last_bits,
  input  logic                  i_pop,
  output logic                  o_ready,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [CNT_W-1:0]      o_len
);

  logic                  r_full;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [CNT_W-1:0]      r_len;
  logic                  w_hs;
  logic                  w_full_nxt;

  assign w_hs       = i_valid & r_ready;
  assign w_full_nxt = w_hs | (r_full & ~i_pop);

  // Capture a word on handshake; ready is kept as its own register mirroring ~full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= ~w_full_nxt;
      if (w_hs) begin
        r_data <= i_data;
        r_last <= i_last;
        r_len  <= i_last ? i_last_bits : CNT_W'(DATA_WIDTH - 1);
      end
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_len   = r_len;

endmodule

// File: rtl/tx_serializer.sv
// Parallel-to-serial transmitter: streams words LSB first with a per-bit valid,
// chains back-to-back words without a bubble, and flags frame completion.
module tx_serializer
  import phy_wifi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  last_word,
  input  logic [CNT_W-1:0]      last_bits,
  input  logic                  en_tx_irq,
  input  logic                  clear_tx_irq,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  tx_irq
);

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_cur_len;
  logic                  r_cur_last;
  logic                  r_bit_valid;
  logic                  r_underrun;
  logic                  r_irq;

  logic                  w_hold_full;
  logic [DATA_WIDTH-1:0] w_hold_data;
  logic                  w_hold_last;
  logic [CNT_W-1:0]      w_hold_len;
  logic                  w_final;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_stop;
  logic                  w_underrun_nxt;

  tx_hold_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (data_valid),
    .i_data      (data_in),
    .i_last      (last_word),
    .i_last_bits (last_bits),
    .i_pop       (w_pop),
    .o_ready     (data_ready),
    .o_full      (w_hold_full),
    .o_data      (w_hold_data),
    .o_last      (w_hold_last),
    .o_len       (w_hold_len)
  );

  // The bit on the line is bit r_cnt of the current word; the final one is at cur_len.
  assign w_final = (r_cnt == r_cur_len);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and shifter control decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_load         = 1'b0;
    w_adv          = 1'b0;
    w_stop         = 1'b0;
    w_underrun_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hold_full) begin
          w_load      = 1'b1;
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_final) begin
          w_adv = 1'b1;
        end else if (r_cur_last) begin
          w_stop      = 1'b1;
          w_state_nxt = DONE;
        end else if (w_hold_full) begin
          w_load = 1'b1;
          w_pop  = 1'b1;
        end else begin
          w_stop         = 1'b1;
          w_underrun_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter; the register is zeroed between words so that
  // nothing beyond the final bit ever reaches bit_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_cur_len   <= '0;
      r_cur_last  <= 1'b0;
      r_bit_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_underrun_nxt;
      if (w_load) begin
        r_shift     <= w_hold_data;
        r_cnt       <= '0;
        r_cur_len   <= w_hold_len;
        r_cur_last  <= w_hold_last;
        r_bit_valid <= 1'b1;
      end else if (w_adv) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (w_stop) begin
        r_shift     <= '0;
        r_bit_valid <= 1'b0;
      end
    end
  end

  // Sticky completion interrupt; a set in DONE wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_irq <= 1'b0;
    else if ((r_state == DONE) && en_tx_irq)  r_irq <= 1'b1;
    else if (clear_tx_irq)                    r_irq <= 1'b0;
  end

  assign bit_out   = r_shift[0];
  assign bit_valid = r_bit_valid;
  assign busy      = (r_state != IDLE) || w_hold_full;
  assign underrun  = r_underrun;
  assign tx_irq    = r_irq;

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer: expected bits are queued at each
// handshake and compared as the serial stream appears.
module tb_tx_serializer;

  localparam int DW = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          last_word = 1'b0;
  logic [CW-1:0] last_bits = '0;
  logic          en_tx_irq = 1'b1;
  logic          clear_tx_irq = 1'b0;
  logic          bit_out;
  logic          bit_valid;
  logic          busy;
  logic          underrun;
  logic          tx_irq;

  int   errors = 0;
  int   checks = 0;
  int   nvalid = 0;
  int   nunder = 0;
  int   run = 0;
  int   max_run = 0;
  logic q[$];

  tx_serializer #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .last_word    (last_word),
    .last_bits    (last_bits),
    .en_tx_irq    (en_tx_irq),
    .clear_tx_irq (clear_tx_irq),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .underrun     (underrun),
    .tx_irq       (tx_irq)
  );

  always #5 clk = ~clk;

  // Serial monitor: every valid bit is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (bit_valid) begin
        nvalid++;
        run++;
        if (run > max_run) max_run = run;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: bit_valid=1 bit_out=%0b but no bit expected", bit_out);
        end else begin
          logic exp_b;
          exp_b = q.pop_front();
          if (bit_out !== exp_b) begin
            errors++;
            $display("FAIL serial_bit: got %0b expected %0b at t=%0t", bit_out, exp_b, $time);
          end
        end
      end else begin
        run = 0;
      end
      if (underrun) nunder++;
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic lw, input logic [CW-1:0] lb);
    int n;
    int k;
    k = 0;
    @(negedge clk);
    while (data_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      errors++; checks++;
      $display("FAIL send_timeout: data_ready=%0b expected 1 within 200 cycles", data_ready);
    end
    data_in = d; last_word = lw; last_bits = lb; data_valid = 1'b1;
    n = lw ? int'(lb) + 1 : DW;
    for (int i = 0; i < n; i++) q.push_back(d[i]);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in = '0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((busy !== 1'b0 || q.size() != 0) && k < 500);
    checks++;
    if (k >= 500) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%0b pending_bits=%0d expected 0/0", name, busy, q.size());
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_tx_irq = 1'b1;
    @(posedge clk);
    #1;
    clear_tx_irq = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bit_out, bit_valid, data_ready, busy, underrun, tx_irq} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_state: out/vld/rdy/busy/und/irq=%b expected 001000",
               {bit_out, bit_valid, data_ready, busy, underrun, tx_irq});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int base;
    en_tx_irq = 1'b1;
    base = nvalid; max_run = 0;
    send_word(32'hA5A5_00FF, 1'b1, 5'd31);
    @(negedge clk);
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++; $display("FAIL latency_k1: bit_valid=%0b expected 0", bit_valid);
    end
    @(negedge clk);
    checks++;
    if (bit_valid !== 1'b1) begin
      errors++; $display("FAIL latency_k2: bit_valid=%0b expected 1", bit_valid);
    end
    wait_idle("single");
    checks++;
    if (nvalid - base != 32 || max_run != 32) begin
      errors++; $display("FAIL single_count: bits=%0d run=%0d expected 32/32", nvalid - base, max_run);
    end
    checks++;
    if (tx_irq !== 1'b1) begin
      errors++; $display("FAIL single_irq: tx_irq=%0b expected 1", tx_irq);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int ubase;
    pulse_clear();
    base = nvalid; ubase = nunder; max_run = 0;
    send_word(32'h0000_0001, 1'b0, 5'd0);
    send_word(32'h8000_0000, 1'b1, 5'd31);
    wait_idle("b2b");
    checks++;
    if (nvalid - base != 64 || max_run != 64) begin
      errors++; $display("FAIL b2b_contiguous: bits=%0d run=%0d expected 64/64", nvalid - base, max_run);
    end
    checks++;
    if (nunder != ubase) begin
      errors++; $display("FAIL b2b_underrun: pulses=%0d expected 0", nunder - ubase);
    end
  endtask

  task automatic test_partial_word();
    int base;
    pulse_clear();
    base = nvalid;
    send_word(32'h00FF_FFFF, 1'b1, 5'd23);
    wait_idle("partial");
    checks++;
    if (nvalid - base != 24) begin
      errors++; $display("FAIL partial_count: bits=%0d expected 24", nvalid - base);
    end
    checks++;
    if (tx_irq !== 1'b1) begin
      errors++; $display("FAIL partial_irq: tx_irq=%0b expected 1", tx_irq);
    end
  endtask

  task automatic test_underrun();
    int base;
    int ubase;
    int k;
    base = nvalid; ubase = nunder;
    send_word(32'h1234_5678, 1'b0, 5'd0);
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (underrun !== 1'b1 && k < 200);
    checks++;
    if (k >= 200 || bit_valid !== 1'b0 || busy !== 1'b0 || nvalid - base != 32) begin
      errors++;
      $display("FAIL underrun_event: seen=%0b vld=%0b busy=%0b bits=%0d expected 1/0/0/32",
               underrun, bit_valid, busy, nvalid - base);
    end
    @(negedge clk);
    #1;
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_pulse: underrun=%0b expected 0 one cycle later", underrun);
    end
    send_word(32'h0000_0003, 1'b1, 5'd2);
    wait_idle("resume");
    checks++;
    if (nvalid - base != 35 || nunder - ubase != 1) begin
      errors++; $display("FAIL underrun_resume: bits=%0d pulses=%0d expected 35/1", nvalid - base, nunder - ubase);
    end
  endtask

  task automatic test_irq();
    int base;
    int k;
    pulse_clear();
    checks++;
    if (tx_irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear: tx_irq=%0b expected 0", tx_irq);
    end
    en_tx_irq = 1'b0;
    base = nvalid;
    send_word(32'hFFFF_FFFE, 1'b1, 5'd0);
    wait_idle("irq_dis");
    checks++;
    if (tx_irq !== 1'b0 || nvalid - base != 1) begin
      errors++; $display("FAIL irq_disabled: tx_irq=%0b bits=%0d expected 0/1", tx_irq, nvalid - base);
    end
    en_tx_irq = 1'b1;
    send_word(32'h0000_0055, 1'b1, 5'd7);
    k = 0;
    while (bit_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    while (bit_valid !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    clear_tx_irq = 1'b1;
    @(posedge clk);
    #1;
    clear_tx_irq = 1'b0;
    checks++;
    if (tx_irq !== 1'b1 || k >= 200) begin
      errors++; $display("FAIL irq_set_wins: tx_irq=%0b expected 1", tx_irq);
    end
    wait_idle("irq_sw");
  endtask

  task automatic test_reset_mid();
    int base;
    int k;
    base = nvalid;
    send_word(32'hDEAD_BEEF, 1'b0, 5'd0);
    send_word(32'h1357_9BDF, 1'b1, 5'd31);
    k = 0;
    while (nvalid - base < 10 && k < 200) begin @(posedge clk); k++; end
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    checks++;
    if ({bit_out, bit_valid, data_ready, busy, underrun, tx_irq} !== 6'b001000 || k >= 200) begin
      errors++;
      $display("FAIL reset_mid: out/vld/rdy/busy/und/irq=%b expected 001000",
               {bit_out, bit_valid, data_ready, busy, underrun, tx_irq});
    end
    @(negedge clk);
    reset = 1'b0;
    base = nvalid;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (nvalid != base || busy !== 1'b0 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_quiet: bits=%0d busy=%0b rdy=%0b expected 0/0/1", nvalid - base, busy, data_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial_word();
    test_underrun();
    test_irq();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
